// File: rtl/canvas_input_conditioner_if.sv
// Raw switch/button pins into the conditioner and the clean levels/strobes out of it.
// master drives the raw pins (board side); slave is the conditioner itself.
interface canvas_input_conditioner_if;
  logic [3:0] buttons_raw;
  logic [2:0] rgb_raw;
  logic       brush_raw;
  logic [3:0] buttons;
  logic [3:0] move_pulse;
  logic [2:0] rgb_sel;
  logic       brush;
  logic       settings_changed;

  modport master (
    output buttons_raw, rgb_raw, brush_raw,
    input  buttons, move_pulse, rgb_sel, brush, settings_changed
  );

  modport slave (
    input  buttons_raw, rgb_raw, brush_raw,
    output buttons, move_pulse, rgb_sel, brush, settings_changed
  );
endinterface

// File: rtl/canvas_input_conditioner.sv
// Synchronise + debounce buttons/colour/brush inputs, generate move strobes with
// hold-to-repeat and a strobe on any paint-setting change.
module canvas_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 4000000,
  parameter int REPEAT_RATE     = 1000000
) (
  input logic                        clk,
  input logic                        rst,
  canvas_input_conditioner_if.slave  io
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  // Buttons are active-low on the pins, so their flops reset to "released".
  localparam logic [7:0]       SYNC_RST   = 8'b1111_0000;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;

  logic [7:0]       w_raw;
  logic [7:0]       w_sync;
  logic [7:0]       r_sync_p0;
  logic [7:0]       r_sync_p1;
  logic [7:0]       r_deb_p2;
  logic [DB_W-1:0]  r_db_cnt [8];
  rpt_state_t       r_state [4];
  rpt_state_t       w_state_nxt [4];
  logic [RPT_W-1:0] r_rpt_cnt [4];
  logic [RPT_W-1:0] w_rpt_cnt_nxt [4];
  logic [3:0]       w_pulse;
  logic [3:0]       w_mask;
  logic [3:0]       r_move_p3;
  logic [3:0]       r_settings_prev;
  logic             r_settings_chg_p3;

  // Bit layout everywhere: [7:4] buttons up/down/right/left, [3:1] RGB, [0] brush.
  assign w_raw = {io.buttons_raw, io.rgb_raw, io.brush_raw};

  // ---- p0/p1: two-flop synchroniser ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= SYNC_RST;
      r_sync_p1 <= SYNC_RST;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_sync = {~r_sync_p1[7:4], r_sync_p1[3:0]};

  // ---- p2: per-bit debounce, level flips after DEBOUNCE_CYCLES straight mismatches ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_p2 <= '0;
      for (int i = 0; i < 8; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_sync[i] == r_deb_p2[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb_p2[i] <= ~r_deb_p2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Repeat FSMs. IDLE with the level high can only be the first high cycle,
  // because any high level moves the FSM out of IDLE on the next edge.
  always_comb begin
    w_pulse = '0;
    for (int d = 0; d < 4; d++) begin
      w_state_nxt[d]   = r_state[d];
      w_rpt_cnt_nxt[d] = r_rpt_cnt[d];
      if (!r_deb_p2[4+d]) begin
        w_state_nxt[d]   = S_IDLE;
        w_rpt_cnt_nxt[d] = '0;
      end else begin
        case (r_state[d])
          S_IDLE: begin
            w_pulse[d]       = 1'b1;
            w_state_nxt[d]   = S_DELAY;
            w_rpt_cnt_nxt[d] = '0;
          end
          S_DELAY: begin
            if (r_rpt_cnt[d] == DELAY_LAST) begin
              w_pulse[d]       = 1'b1;
              w_state_nxt[d]   = S_REPEAT;
              w_rpt_cnt_nxt[d] = '0;
            end else begin
              w_rpt_cnt_nxt[d] = r_rpt_cnt[d] + RPT_W'(1);
            end
          end
          S_REPEAT: begin
            if (r_rpt_cnt[d] == RATE_LAST) begin
              w_pulse[d]       = 1'b1;
              w_rpt_cnt_nxt[d] = '0;
            end else begin
              w_rpt_cnt_nxt[d] = r_rpt_cnt[d] + RPT_W'(1);
            end
          end
          default: begin
            w_state_nxt[d]   = S_IDLE;
            w_rpt_cnt_nxt[d] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        r_state[d]   <= S_IDLE;
        r_rpt_cnt[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        r_state[d]   <= w_state_nxt[d];
        r_rpt_cnt[d] <= w_rpt_cnt_nxt[d];
      end
    end
  end

  // Opposing directions held together cancel; the FSMs behind them keep counting.
  assign w_mask = {{2{r_deb_p2[7] & r_deb_p2[6]}}, {2{r_deb_p2[5] & r_deb_p2[4]}}};

  // ---- p3: registered strobes ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_move_p3         <= '0;
      r_settings_prev   <= '0;
      r_settings_chg_p3 <= 1'b0;
    end else begin
      r_move_p3         <= w_pulse & ~w_mask;
      r_settings_prev   <= r_deb_p2[3:0];
      r_settings_chg_p3 <= (r_deb_p2[3:0] != r_settings_prev);
    end
  end

  assign io.buttons          = r_deb_p2[7:4];
  assign io.rgb_sel          = r_deb_p2[3:1];
  assign io.brush            = r_deb_p2[0];
  assign io.move_pulse       = r_move_p3;
  assign io.settings_changed = r_settings_chg_p3;
endmodule
